move_controller: RTL and testbench
==================================

# move_controller

Sequences one chess move at a time through the combinational `board_validator` and owns the authoritative 8x8 board state. It accepts a move request from the UI/cursor logic over a valid/ready handshake and runs pre-checks (turn ownership, destination, pawn direction). It drives the validator with a side-to-move-oriented view of the board, commits legal moves, tracks captures and king capture, and returns one response per accepted request.

## Interface

Parameters:
- `EMPTY`, 4'd15, board code for an empty square.

Piece codes:
- 0-5 = side 0: rook, knight, bishop, queen, king, pawn.
- 6-11 = side 1, same order.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, synchronous and active-low.
- `new_game`  in  1  level; re-initialises board, turn and FSM.
- `req_valid`  in  1  move request valid.
- `req_ready`  out  1  controller can accept a request.
- `req_old_x`, `req_old_y`, `req_new_x`, `req_new_y`  in  3 each  absolute source/destination coordinates, board[y][x].
- `v_old_x`, `v_old_y`, `v_new_x`, `v_new_y`  out  3 each  oriented coordinates to the validator.
- `v_piece_type`  out  4  source piece code to the validator.
- `v_board`  out  4 x [8][8]  oriented board to the validator.
- `v_valid_input`  out  1  validator strobe.
- `v_valid_move`, `v_valid_output`  in  1 each  validator result.
- `board_out`  out  4 x [8][8]  absolute board.
- `turn`  out  1  side to move.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_code`  out  2  result code:
  - 0 = ok.
  - 1 = source empty or not owned.
  - 2 = destination own piece, or null move.
  - 3 = illegal (validator or pawn direction).
- `captured`  out  4  piece removed by the last ok move, or `EMPTY`.
- `game_over`  out  1  a king (code 4 or 10) has been captured.

## Operation

- **Orientation.**
  - When `turn`=0, the validator view is the identity.
  - When `turn`=1, the view is rotated 180°: `v_board[y][x] = board[7-y][7-x]`, and each coordinate c becomes 7-c (3-bit subtraction).
  - In both cases the mover's pawns start on oriented row 6 and advance toward lower y.
- **Initial board.**
  - Row 7: 0,1,2,3,4,2,1,0.
  - Row 6: all 5.
  - Rows 2-5: `EMPTY`.
  - Row 1: all 11.
  - Row 0: 6,7,8,9,10,8,7,6.
  - `turn` = 0.
- **FSM states:** IDLE, CHECK, VALIDATE, COMMIT, RESP.
- **IDLE**
  - `req_ready = (state==IDLE) && !new_game && !game_over`.
  - On `req_valid && req_ready`, register coordinates and the source code; go to CHECK.
- **CHECK** (rules evaluated in order)
  - Source empty, or source not in the mover's range (0-5 for turn 0, 6-11 for turn 1) → code 1, go to RESP.
  - Source equals destination, or destination holds a mover's piece → code 2, go to RESP.
  - Otherwise go to VALIDATE.
- **VALIDATE**
  - `v_valid_input`=1 for exactly this cycle; sample `v_valid_move`.
  - Any of these → code 3, go to RESP:
    - `v_valid_output`=0;
    - `v_valid_move`=0;
    - pawn with oriented new_y >= old_y.
  - Otherwise go to COMMIT.
- **COMMIT**
  - `captured` <= old destination code.
  - Write destination <= source code and source <= `EMPTY`.
  - Toggle `turn`.
  - Set `game_over` if the captured code is 4 or 10.
  - Code 0, go to RESP.
- **RESP:** `rsp_valid`=1 with `rsp_code` held; go to IDLE.
- **Other registers.** `captured` changes only in COMMIT. `rsp_code` holds its value until the next response.
- **Reset and new_game.**
  - `new_game`=1 in any state acts like reset, except that `rsp_code` keeps its value.
  - The in-flight request is dropped with no response.
  - `new_game` has priority over `req_valid` in the same cycle.
- **Out of scope.** No castling, en passant, promotion or check detection in this block.

## Timing

- **Reset values:**
  - state IDLE, `req_ready`=1;
  - `rsp_valid`=0, `rsp_code`=0;
  - `captured`=`EMPTY`, `turn`=0, `game_over`=0;
  - `v_valid_input`=0, `board_out`=initial board.
- **Latency.** The handshake occurs in cycle 0. `rsp_valid` then rises in:
  - cycle 2 for code 1 or 2;
  - cycle 3 for code 3;
  - cycle 4 for code 0.
- **Commit visibility.** `board_out`, `turn` and `captured` show the new values in the RESP cycle, together with `rsp_valid`.
- **Request rules.**
  - `req_ready`=0 from CHECK through RESP; at most one outstanding request.
  - `req_*` are sampled only at the handshake; changes afterwards are ignored.
- **Validator path.** `v_*` outputs come from registered request state plus `turn`, so they are stable throughout VALIDATE. The validator is combinational; its result is sampled in the same cycle.
- **Game over.** After `game_over`, `req_ready` stays 0 until `new_game` or reset.

## Test plan

- **Reset:** hold `reset_n`=0 for 2 cycles → initial board on `board_out`, `turn`=0, `req_ready`=1, `rsp_valid`=0, `captured`=15.
- **Double pawn push:** request (4,6)->(4,4) → `rsp_valid` in cycle 4 with code 0; board[4][4]=5, board[6][4]=15; `turn`=1; validator saw `v_old_y`=6.
- **Side-1 orientation:** then request (3,1)->(3,3) → validator sees (4,6)->(4,4); code 0, board[3][3]=11, `turn`=0. A follow-up side-0 request (0,7)->(0,4) → code 3 in cycle 3 (rook path blocked by pawn at (0,6)).
- **Pre-check rejects:** from the initial board:
  - request (4,4)->(4,3) → code 1 in cycle 2, board and `turn` unchanged;
  - request (0,7)->(1,7) → code 2.
- **Capture and game over:** preload a legal sequence ending with a side-0 queen taking the king at (4,0) → code 0, `captured`=10, `game_over`=1, `req_ready` stays 0; pulse `new_game` → initial board, `game_over`=0.
- **Abort:** assert `new_game` in the VALIDATE cycle → no `rsp_valid`, board initial, `turn`=0, `req_ready`=1 next cycle. A `req_valid` asserted together with `new_game` is not accepted.

Source files
------------

// File: rtl/move_controller.sv
// Move sequencer for a chess board: accepts one move request, pre-checks it,
// consults an external combinational validator on a side-oriented view, and commits legal moves.
module move_controller #(
    parameter logic [3:0] EMPTY = 4'd15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  new_game,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_old_x,
    input  logic [2:0]            req_old_y,
    input  logic [2:0]            req_new_x,
    input  logic [2:0]            req_new_y,
    output logic [2:0]            v_old_x,
    output logic [2:0]            v_old_y,
    output logic [2:0]            v_new_x,
    output logic [2:0]            v_new_y,
    output logic [3:0]            v_piece_type,
    output logic [7:0][7:0][3:0]  v_board,
    output logic                  v_valid_input,
    input  logic                  v_valid_move,
    input  logic                  v_valid_output,
    output logic [7:0][7:0][3:0]  board_out,
    output logic                  turn,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_code,
    output logic [3:0]            captured,
    output logic                  game_over
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK    = 3'd1,
        S_VALIDATE = 3'd2,
        S_COMMIT   = 3'd3,
        S_RESP     = 3'd4
    } state_e;

    function automatic logic [7:0][7:0][3:0] init_board();
        logic [7:0][7:0][3:0] b;
        logic [7:0][3:0]      back;
        back = {4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                b[y][x] = EMPTY;
            end
        end
        for (int x = 0; x < 8; x++) begin
            b[7][x] = back[x];
            b[6][x] = 4'd5;
            b[1][x] = 4'd11;
            b[0][x] = back[x] + 4'd6;
        end
        return b;
    endfunction

    function automatic logic owned(input logic [3:0] code, input logic side);
        return side ? ((code >= 4'd6) && (code <= 4'd11)) : (code <= 4'd5);
    endfunction

    state_e               state_q, state_d;
    logic [7:0][7:0][3:0] board_q, board_d;
    logic                 turn_q, turn_d;
    logic [2:0]           ox_q, ox_d, oy_q, oy_d, nx_q, nx_d, ny_q, ny_d;
    logic [3:0]           piece_q, piece_d;
    logic [1:0]           rsp_code_q, rsp_code_d;
    logic [3:0]           captured_q, captured_d;
    logic                 game_over_q, game_over_d;

    logic                 accept_s, src_bad_s, dst_bad_s, val_bad_s, is_pawn_s;
    logic [3:0]           dst_code_s;

    // Request acceptance and pre-check / validation verdicts
    always_comb begin
        req_ready  = (state_q == S_IDLE) && !new_game && !game_over_q;
        accept_s   = req_valid && req_ready;
        dst_code_s = board_q[ny_q][nx_q];
        src_bad_s  = !owned(piece_q, turn_q);
        dst_bad_s  = ((ox_q == nx_q) && (oy_q == ny_q)) || owned(dst_code_s, turn_q);
        is_pawn_s  = (piece_q == 4'd5) || (piece_q == 4'd11);
        // Pawns of either side must advance toward lower oriented y
        val_bad_s  = !v_valid_output || !v_valid_move || (is_pawn_s && (v_new_y >= v_old_y));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (new_game) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:     state_d = accept_s ? S_CHECK : S_IDLE;
                S_CHECK:    state_d = (src_bad_s || dst_bad_s) ? S_RESP : S_VALIDATE;
                S_VALIDATE: state_d = val_bad_s ? S_RESP : S_COMMIT;
                S_COMMIT:   state_d = S_RESP;
                S_RESP:     state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    // Datapath next values: request capture, response code, board commit
    always_comb begin
        board_d     = board_q;
        turn_d      = turn_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        nx_d        = nx_q;
        ny_d        = ny_q;
        piece_d     = piece_q;
        rsp_code_d  = rsp_code_q;
        captured_d  = captured_q;
        game_over_d = game_over_q;
        if (new_game) begin
            board_d     = init_board();
            turn_d      = 1'b0;
            captured_d  = EMPTY;
            game_over_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        ox_d    = req_old_x;
                        oy_d    = req_old_y;
                        nx_d    = req_new_x;
                        ny_d    = req_new_y;
                        piece_d = board_q[req_old_y][req_old_x];
                    end else begin
                        piece_d = piece_q;
                    end
                end
                S_CHECK: begin
                    if (src_bad_s) begin
                        rsp_code_d = 2'd1;
                    end else if (dst_bad_s) begin
                        rsp_code_d = 2'd2;
                    end else begin
                        rsp_code_d = rsp_code_q;
                    end
                end
                S_VALIDATE: begin
                    if (val_bad_s) begin
                        rsp_code_d = 2'd3;
                    end else begin
                        rsp_code_d = rsp_code_q;
                    end
                end
                S_COMMIT: begin
                    captured_d         = dst_code_s;
                    board_d[ny_q][nx_q] = piece_q;
                    board_d[oy_q][ox_q] = EMPTY;
                    turn_d             = !turn_q;
                    rsp_code_d         = 2'd0;
                    if ((dst_code_s == 4'd4) || (dst_code_s == 4'd10)) begin
                        game_over_d = 1'b1;
                    end else begin
                        game_over_d = game_over_q;
                    end
                end
                default: begin
                    rsp_code_d = rsp_code_q;
                end
            endcase
        end
    end

    // Output decode: oriented validator view and status
    always_comb begin
        v_old_x       = turn_q ? (3'd7 - ox_q) : ox_q;
        v_old_y       = turn_q ? (3'd7 - oy_q) : oy_q;
        v_new_x       = turn_q ? (3'd7 - nx_q) : nx_q;
        v_new_y       = turn_q ? (3'd7 - ny_q) : ny_q;
        v_piece_type  = piece_q;
        v_valid_input = (state_q == S_VALIDATE);
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                v_board[y][x] = turn_q ? board_q[7-y][7-x] : board_q[y][x];
            end
        end
        board_out = board_q;
        turn      = turn_q;
        rsp_valid = (state_q == S_RESP);
        rsp_code  = rsp_code_q;
        captured  = captured_q;
        game_over = game_over_q;
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            board_q     <= init_board();
            turn_q      <= 1'b0;
            ox_q        <= 3'd0;
            oy_q        <= 3'd0;
            nx_q        <= 3'd0;
            ny_q        <= 3'd0;
            piece_q     <= EMPTY;
            rsp_code_q  <= 2'd0;
            captured_q  <= EMPTY;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            turn_q      <= turn_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            nx_q        <= nx_d;
            ny_q        <= ny_d;
            piece_q     <= piece_d;
            rsp_code_q  <= rsp_code_d;
            captured_q  <= captured_d;
            game_over_q <= game_over_d;
        end
    end

endmodule

// File: tb/tb_move_controller.sv
// Scoreboard bench for move_controller with a behavioural board_validator stand-in
// and an independent reference model of the board, turn, capture and response timing.
module tb_move_controller;

    logic                 clk = 1'b0;
    logic                 reset_n, new_game, req_valid, req_ready;
    logic [2:0]           req_old_x, req_old_y, req_new_x, req_new_y;
    logic [2:0]           v_old_x, v_old_y, v_new_x, v_new_y;
    logic [3:0]           v_piece_type;
    logic [7:0][7:0][3:0] v_board;
    logic                 v_valid_input, v_valid_move, v_valid_output;
    logic [7:0][7:0][3:0] board_out;
    logic                 turn, rsp_valid, game_over;
    logic [1:0]           rsp_code;
    logic [3:0]           captured;

    always #5 clk = ~clk;

    move_controller #(.EMPTY(4'd15)) dut (
        .clk(clk), .reset_n(reset_n), .new_game(new_game),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_old_x(req_old_x), .req_old_y(req_old_y),
        .req_new_x(req_new_x), .req_new_y(req_new_y),
        .v_old_x(v_old_x), .v_old_y(v_old_y), .v_new_x(v_new_x), .v_new_y(v_new_y),
        .v_piece_type(v_piece_type), .v_board(v_board), .v_valid_input(v_valid_input),
        .v_valid_move(v_valid_move), .v_valid_output(v_valid_output),
        .board_out(board_out), .turn(turn), .rsp_valid(rsp_valid), .rsp_code(rsp_code),
        .captured(captured), .game_over(game_over)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct { int code; int start; } exp_t;
    exp_t sb_q[$];

    logic [7:0][7:0][3:0] mb;
    logic                 mt, mgo, force_valid;
    logic [3:0]           mcap;
    int                   last_code = 0;
    int                   seen_ox, seen_oy, seen_nx, seen_ny;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0][7:0][3:0] start_board();
        logic [7:0][7:0][3:0] b;
        int back [8] = '{0, 1, 2, 3, 4, 2, 1, 0};
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) b[y][x] = 4'd15;
        for (int x = 0; x < 8; x++) begin
            b[7][x] = 4'(back[x]);
            b[6][x] = 4'd5;
            b[1][x] = 4'd11;
            b[0][x] = 4'(back[x] + 6);
        end
        return b;
    endfunction

    function automatic bit own(input logic [3:0] c, input logic side);
        return side ? (c >= 4'd6 && c <= 4'd11) : (c <= 4'd5);
    endfunction

    // Piece movement rules on an oriented board (mover's pawns go toward lower y)
    function automatic bit legal(input logic [7:0][7:0][3:0] b, input logic [3:0] p,
                                 input int ox, input int oy, input int nx, input int ny);
        int dx, dy, adx, ady, sx, sy, n;
        logic [3:0] k, d;
        bit side, path;
        dx = nx - ox; dy = ny - oy;
        adx = (dx < 0) ? -dx : dx;
        ady = (dy < 0) ? -dy : dy;
        sx = (dx > 0) ? 1 : ((dx < 0) ? -1 : 0);
        sy = (dy > 0) ? 1 : ((dy < 0) ? -1 : 0);
        n = (adx > ady) ? adx : ady;
        if (p > 4'd11) return 1'b0;
        side = (p >= 4'd6);
        k = side ? (p - 4'd6) : p;
        d = b[ny][nx];
        if (d != 4'd15 && ((d >= 4'd6) == side)) return 1'b0;
        path = 1'b1;
        for (int i = 1; i < n; i++)
            if (b[oy + i*sy][ox + i*sx] != 4'd15) path = 1'b0;
        case (k)
            4'd0: return (dx == 0 || dy == 0) && n > 0 && path;
            4'd1: return adx * ady == 2;
            4'd2: return adx == ady && n > 0 && path;
            4'd3: return (dx == 0 || dy == 0 || adx == ady) && n > 0 && path;
            4'd4: return n == 1;
            4'd5: return (dx == 0 && dy == -1 && d == 4'd15) ||
                         (dx == 0 && dy == -2 && oy == 6 && d == 4'd15 && path) ||
                         (adx == 1 && dy == -1 && d != 4'd15);
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        v_valid_output = v_valid_input;
        v_valid_move   = force_valid || legal(v_board, v_piece_type, int'(v_old_x), int'(v_old_y),
                                              int'(v_new_x), int'(v_new_y));
    end

    function automatic int ref_code(input int ox, input int oy, input int nx, input int ny);
        logic [7:0][7:0][3:0] ob;
        logic [3:0] s, d;
        int oox, ooy, onx, ony;
        s = mb[oy][ox];
        d = mb[ny][nx];
        if (!own(s, mt)) return 1;
        if ((ox == nx && oy == ny) || own(d, mt)) return 2;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) ob[y][x] = mt ? mb[7-y][7-x] : mb[y][x];
        oox = mt ? 7 - ox : ox; ooy = mt ? 7 - oy : oy;
        onx = mt ? 7 - nx : nx; ony = mt ? 7 - ny : ny;
        if (!(force_valid || legal(ob, s, oox, ooy, onx, ony))) return 3;
        if ((s == 4'd5 || s == 4'd11) && ony >= ooy) return 3;
        return 0;
    endfunction

    task automatic reset_model();
        mb = start_board(); mt = 1'b0; mcap = 4'd15; mgo = 1'b0;
    endtask

    // Response monitor: pops the scoreboard and compares response and committed state
    always @(negedge clk) begin
        exp_t e;
        int lat;
        if (v_valid_input) begin
            seen_ox = v_old_x; seen_oy = v_old_y; seen_nx = v_new_x; seen_ny = v_new_y;
        end
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_rsp", 1, 0);
            end else begin
                e = sb_q.pop_front();
                lat = (e.code == 0) ? 4 : ((e.code == 3) ? 3 : 2);
                last_code = e.code;
                check_val("rsp_code", rsp_code, e.code);
                check_val("rsp_latency", cyc - e.start, lat);
                check_val("board", board_out, mb);
                check_val("turn", turn, mt);
                check_val("captured", captured, mcap);
                check_val("game_over", game_over, mgo);
            end
        end
    end

    task automatic send(input int ox, input int oy, input int nx, input int ny);
        int t, code;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        if (!req_ready) begin
            check_val("req_ready_timeout", 0, 1);
            return;
        end
        req_valid = 1'b1;
        req_old_x = 3'(ox); req_old_y = 3'(oy); req_new_x = 3'(nx); req_new_y = 3'(ny);
        code = ref_code(ox, oy, nx, ny);
        sb_q.push_back('{code, cyc});
        if (code == 0) begin
            mcap = mb[ny][nx];
            mb[ny][nx] = mb[oy][ox];
            mb[oy][ox] = 4'd15;
            mt = ~mt;
            if (mcap == 4'd4 || mcap == 4'd10) mgo = 1'b1;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_old_x = 3'($urandom); req_old_y = 3'($urandom);
        req_new_x = 3'($urandom); req_new_y = 3'($urandom);
        t = 0;
        while (sb_q.size() != 0 && t < 20) begin @(negedge clk); t++; end
        if (sb_q.size() != 0) begin
            check_val("rsp_timeout", 0, 1);
            sb_q.delete();
        end
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        reset_model();
        #1;
        check_val("ng_board", board_out, mb);
        check_val("ng_turn", turn, 0);
        check_val("ng_captured", captured, 15);
        check_val("ng_game_over", game_over, 0);
        check_val("ng_req_ready", req_ready, 1);
        check_val("ng_rsp_code_kept", rsp_code, last_code);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; new_game = 1'b0; req_valid = 1'b0; force_valid = 1'b0;
        req_old_x = 3'd0; req_old_y = 3'd0; req_new_x = 3'd0; req_new_y = 3'd0;
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_board", board_out, mb);
        check_val("rst_turn", turn, 0);
        check_val("rst_req_ready", req_ready, 1);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_rsp_code", rsp_code, 0);
        check_val("rst_captured", captured, 15);
        check_val("rst_game_over", game_over, 0);
        check_val("rst_v_valid_input", v_valid_input, 0);
        reset_n = 1'b1;

        send(4, 4, 4, 3);
        send(0, 7, 1, 7);
        send(0, 1, 0, 2);
        send(4, 6, 4, 4);
        check_val("push_seen_old_y", seen_oy, 6);
        send(3, 1, 3, 3);
        check_val("side1_seen_coords", {seen_ox[2:0], seen_oy[2:0], seen_nx[2:0], seen_ny[2:0]},
                  {3'd4, 3'd6, 3'd4, 3'd4});
        send(0, 7, 0, 4);
        force_valid = 1'b1;
        send(4, 4, 4, 5);
        send(3, 3, 3, 4);
        force_valid = 1'b0;

        pulse_new_game();
        send(4, 6, 4, 4);
        send(0, 1, 0, 2);
        send(3, 7, 7, 3);
        send(0, 2, 0, 3);
        send(7, 3, 5, 1);
        send(0, 3, 0, 4);
        send(5, 1, 4, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_old_x = 3'd0; req_old_y = 3'd4; req_new_x = 3'd0; req_new_y = 3'd5;
            check_val("go_req_ready", req_ready, 0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        pulse_new_game();

        // Abort an in-flight request in its validate cycle
        @(negedge clk);
        req_valid = 1'b1;
        req_old_x = 3'd4; req_old_y = 3'd6; req_new_x = 3'd4; req_new_y = 3'd4;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("abort_in_validate", v_valid_input, 1);
        new_game = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        check_val("abort_ready_during_ng", req_ready, 0);
        @(negedge clk);
        new_game = 1'b0;
        req_valid = 1'b0;
        #1;
        check_val("abort_req_ready", req_ready, 1);
        repeat (6) @(negedge clk);
        check_val("abort_board", board_out, mb);
        check_val("abort_turn", turn, 0);
        check_val("abort_v_valid_input", v_valid_input, 0);

        send(1, 7, 2, 5);
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
